register_file: RTL
==================

// Module: register_file
// PURPOSE
//   Parametrised general-purpose register bank for the 16-bit datapath. It generalises the
//   single load-enabled register into DEPTH words of WIDTH bits, with two read ports and one
//   write port. It sits between the control unit and the ALU.
//   It adds async reset, an optional hardwired-zero R0, write-to-read bypass and a clear-all strobe.
// PARAMETERS
//   WIDTH      16  data width of each register, in bits
//   DEPTH      8   number of registers; must be a power of two and >= 2
//   AW         3   address width; equals $clog2(DEPTH)
//   ZERO_R0    1   1: register 0 always reads 0 and ignores writes
//   BYPASS     1   1: a read of the address being written this cycle returns wr_data
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high; clears every register to 0
//   wr_en      in   1      write strobe; sampled at the rising edge of clk
//   wr_addr    in   AW     write address
//   wr_data    in   WIDTH  write data
//   clear      in   1      synchronous clear-all; takes priority over wr_en
//   rd_addr_a  in   AW     read port A address
//   rd_data_a  out  WIDTH  read port A data; combinational
//   rd_addr_b  in   AW     read port B address
//   rd_data_b  out  WIDTH  read port B data; combinational
//   wr_count   out  8      saturating count of accepted writes, for debug
// BEHAVIOUR
//   - Clocking: one clock (clk); reset is asynchronous and active-high.
//   - Reset: asserting reset immediately drives all registers, and therefore all read data, to 0.
//     It also sets wr_count = 0.
//   - Reset mid-operation: a write in the same cycle as reset is lost.
//   - Write: at posedge clk, with wr_en=1 and clear=0, regs[wr_addr] <= wr_data.
//     Write latency is 1 cycle; all other registers hold their values.
//   - Discarded write: a write to address 0 with ZERO_R0=1 is dropped and not counted.
//   - Clear: at posedge clk with clear=1, all registers become 0 and wr_count becomes 0.
//     A simultaneous wr_en is ignored.
//   - Read: rd_data_x = regs[rd_addr_x] combinationally, with no clock latency.
//     Both ports may read the same address at the same time.
//   - Bypass, BYPASS=1: when wr_en=1, clear=0 and rd_addr_x == wr_addr, rd_data_x = wr_data in the
//     same cycle. This does not apply to a discarded R0 write.
//   - Bypass, BYPASS=0: the old contents are returned until the clock edge.
//   - ZERO_R0=1: rd_data_x is always 0 when rd_addr_x == 0, including when bypass would apply.
//   - wr_count: increments by 1 per accepted write and saturates at 8'hFF, with no wrap-around.
//   - Addressing: all AW-bit addresses are in range because DEPTH = 2^AW.
//   - X handling: wr_data may be X while wr_en=0; it must never reach the storage.
// STRUCTURE
//   - Shared package/header (regfile_defs.vh):
//     - `DATA_W (16)
//     - `REG_COUNT (8)
//     - `REG_AW (3)
//     - `REG_ZERO (3'd0)
//   - Sub-module register_n (WIDTH param; ports clk, reset, load, clr, d, q):
//     - async-reset, load-enabled flop word; successor of the single-register block.
//     - One instance per register, built with a generate loop.
//     - For ZERO_R0=1, index 0 is a constant 0 instead of an instance.
//   - Top level contains:
//     - write decoder producing one-hot load signals
//     - two read multiplexers with bypass compare
//     - wr_count saturating counter
// TESTING
//   1. Reset: reset=1 for 2 cycles, then release.
//      -> rd_data_a = rd_data_b = 0 for every address; wr_count = 0.
//   2. Write then read: write 16'h1234 to R5.
//      -> rd_addr_a=5 gives 16'h1234 from the next cycle; wr_count = 1.
//   3. Hardwired R0: write 16'hFFFF to R0.
//      -> rd_data_a(0) = 0; wr_count unchanged.
//      -> with ZERO_R0=0 the read instead returns 16'hFFFF.
//   4. Bypass: wr_en=1, wr_addr=3, wr_data=16'hBEEF, rd_addr_b=3, checked in the same cycle.
//      -> rd_data_b = 16'hBEEF before the edge.
//      -> with BYPASS=0 the read returns the old value until the edge.
//   5. Clear priority: fill R1..R7 with 16'h0001..16'h0007, then pulse clear=1 with wr_en=1,
//      wr_addr=2, wr_data=16'hAAAA.
//      -> all registers = 0 afterwards; wr_count = 0.
//   6. Async reset plus saturation:
//      -> assert reset between clock edges: outputs are 0 at once, without waiting for clk.
//      -> perform 300 writes: wr_count stops at 8'hFF.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared definitions for the general-purpose register bank.
// Holds default geometry, the debug counter width and the saturating increment helper.
// Imported by the register word and the bank top level.
package register_file_pkg;

  localparam int         DATA_W    = 16;
  localparam int         REG_COUNT = 8;
  localparam int         REG_AW    = 3;
  localparam logic [2:0] REG_ZERO  = 3'd0;

  localparam int         CNT_W     = 8;
  localparam logic [7:0] CNT_MAX   = 8'hFF;

  // Add one, holding at the maximum instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/register_file_register_n.sv
// One storage word of the register bank: load-enabled flop with async reset and sync clear.
// Latency: q reflects d one clock after load is sampled high.
// No handshake; load is a plain strobe and clr wins over load.
module register_n
  import register_file_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Storage: reset and clear zero the word; otherwise load captures d, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/register_file.sv
// Register bank: DEPTH x WIDTH words, two combinational read ports, one write port.
// Latency: writes land one clock after the strobe; reads are combinational (optional bypass).
// No backpressure: every write strobe is taken; clear overrides a coincident write.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int DEPTH   = REG_COUNT,
  parameter int AW      = $clog2(DEPTH),
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [CNT_W-1:0] wr_count
);

  logic [WIDTH-1:0] w_regs [DEPTH];
  logic             w_wr_to_zero;
  logic             w_wr_accept;
  logic [CNT_W-1:0] r_wr_count;

  // A write is accepted unless a clear overrides it or it targets the hardwired R0.
  assign w_wr_to_zero = ZERO_R0 && (wr_addr == '0);
  assign w_wr_accept  = wr_en && !clear && !w_wr_to_zero;

  // Storage words with the write decoder folded in: each word loads only on its own address.
  // The load term is gated by wr_en, so X on wr_data while idle never reaches a flop.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      if (ZERO_R0 && (i == 0)) begin : g_zero
        assign w_regs[i] = '0;
      end else begin : g_reg
        logic w_load;
        assign w_load = w_wr_accept && (wr_addr == AW'(i));
        register_n #(
          .WIDTH (WIDTH)
        ) u_reg (
          .clk   (clk),
          .reset (reset),
          .load  (w_load),
          .clr   (clear),
          .d     (wr_data),
          .q     (w_regs[i])
        );
      end
    end
  endgenerate

  // Read port A: array select, then same-cycle bypass, then R0 override last so it always wins.
  always_comb begin
    rd_data_a = w_regs[rd_addr_a];
    if (BYPASS && w_wr_accept && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
    if (ZERO_R0 && (rd_addr_a == '0)) begin
      rd_data_a = '0;
    end
  end

  // Read port B: identical structure to port A.
  always_comb begin
    rd_data_b = w_regs[rd_addr_b];
    if (BYPASS && w_wr_accept && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
    if (ZERO_R0 && (rd_addr_b == '0)) begin
      rd_data_b = '0;
    end
  end

  // Debug write counter: counts accepted writes only, holds at 8'hFF, zeroed by reset or clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= '0;
    end else if (clear) begin
      r_wr_count <= '0;
    end else if (w_wr_accept) begin
      r_wr_count <= sat_inc(r_wr_count);
    end
  end

  assign wr_count = r_wr_count;

endmodule
